// File: rtl/waveform_sequencer_pkg.sv
// Shared encodings for the waveform playback sequencer: playback modes and channel FSM states.
package waveform_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_CONT    = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_NREPEAT = 2'd2,
        MODE_GATED   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

endpackage

// File: rtl/waveform_sequencer_channel.sv
// One playback channel: IDLE/ARMED/PLAY FSM, segment address counter and sync delay line.
// State | meaning: IDLE = disabled or bad config | ARMED = waiting for trigger | PLAY = stepping through the segment
module waveform_sequencer_channel
    import waveform_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LOOP_WIDTH = 16,
    parameter int SYNC_DELAY = 3
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  trigger_i,
    input  logic                  restart_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    input  logic [LOOP_WIDTH-1:0] loop_count_i,
    output logic [ADDR_WIDTH-1:0] read_address_o,
    output logic                  sync_out_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  config_error_o
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [LOOP_WIDTH-1:0] ONE_L = 1;

    state_e                state_q;
    mode_e                 mode_q;
    mode_e                 mode_in;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [ADDR_WIDTH-1:0] len_in;
    logic [LOOP_WIDTH-1:0] loop_q;
    logic [LOOP_WIDTH-1:0] pass_q;
    logic                  trig_q;
    logic                  sync_raw_q;
    logic                  done_q;
    logic                  err_q;
    logic [SYNC_DELAY-1:0] sync_sr_q;
    logic                  trig_edge;
    logic                  pass_end;
    logic                  enter;
    logic                  reload;
    logic                  load;

    assign mode_in   = mode_e'(mode_i);
    assign len_in    = end_addr_i - start_addr_i;
    assign trig_edge = trigger_i & ~trig_q;
    // rem_q counts addresses left after the current one; zero marks the last of the pass
    assign pass_end  = (state_q == ST_PLAY) && (rem_q == '0);

    always_comb begin
        enter  = 1'b0;
        reload = 1'b0;
        case (state_q)
            ST_IDLE:  enter = (mode_in == MODE_CONT);
            ST_ARMED: enter = (mode_in == MODE_CONT) ||
                              ((mode_in == MODE_GATED) ? trigger_i : trig_edge);
            ST_PLAY: begin
                if (restart_i) begin
                    reload = 1'b1;
                end else if (pass_end) begin
                    case (mode_q)
                        MODE_CONT:    reload = 1'b1;
                        MODE_NREPEAT: reload = (pass_q < loop_q);
                        MODE_GATED:   reload = trigger_i;
                        default:      reload = 1'b0;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign load = enable_i & (enter | reload);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_CONT;
            addr_q     <= '0;
            rem_q      <= '0;
            loop_q     <= '0;
            pass_q     <= '0;
            trig_q     <= 1'b0;
            sync_raw_q <= 1'b0;
            sync_sr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            trig_q       <= trigger_i;
            sync_raw_q   <= 1'b0;
            done_q       <= 1'b0;
            sync_sr_q[0] <= sync_raw_q;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                sync_sr_q[i] <= sync_sr_q[i-1];
            end

            if (!enable_i) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b0;
            end else if (load) begin
                if (len_in == '0) begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                end else begin
                    state_q    <= ST_PLAY;
                    addr_q     <= start_addr_i;
                    rem_q      <= len_in - ONE_A;
                    mode_q     <= mode_in;
                    loop_q     <= loop_count_i;
                    sync_raw_q <= 1'b1;
                    // only a natural wrap advances the pass count; entry and restart start over
                    pass_q     <= ((state_q == ST_PLAY) && !restart_i) ? pass_q + ONE_L : '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARMED;
                    ST_PLAY: begin
                        if (pass_end) begin
                            state_q <= ST_ARMED;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ONE_A;
                            rem_q  <= rem_q - ONE_A;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign read_address_o = addr_q;
    assign sync_out_o     = sync_sr_q[SYNC_DELAY-1];
    assign busy_o         = (state_q == ST_PLAY);
    assign done_o         = done_q;
    assign config_error_o = err_q;

endmodule

// File: rtl/waveform_playback_sequencer.sv
// Multi-channel BRAM read-address generator; one independent playback channel per slice of the flattened buses.
module waveform_playback_sequencer
    import waveform_sequencer_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int LOOP_WIDTH = 16,
    parameter int SYNC_DELAY = 3
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic [CHANNELS-1:0]            enable_i,
    input  logic [CHANNELS-1:0]            trigger_i,
    input  logic [CHANNELS-1:0]            restart_i,
    input  logic [2*CHANNELS-1:0]          mode_i,
    input  logic [ADDR_WIDTH*CHANNELS-1:0] start_addr_i,
    input  logic [ADDR_WIDTH*CHANNELS-1:0] end_addr_i,
    input  logic [LOOP_WIDTH*CHANNELS-1:0] loop_count_i,
    output logic [ADDR_WIDTH*CHANNELS-1:0] read_address_o,
    output logic [CHANNELS-1:0]            sync_out_o,
    output logic [CHANNELS-1:0]            busy_o,
    output logic [CHANNELS-1:0]            done_o,
    output logic [CHANNELS-1:0]            config_error_o
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        waveform_sequencer_channel #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LOOP_WIDTH (LOOP_WIDTH),
            .SYNC_DELAY (SYNC_DELAY)
        ) u_channel (
            .clock_i        (clock_i),
            .reset_ni       (reset_ni),
            .enable_i       (enable_i[g]),
            .trigger_i      (trigger_i[g]),
            .restart_i      (restart_i[g]),
            .mode_i         (mode_i[2*g +: 2]),
            .start_addr_i   (start_addr_i[ADDR_WIDTH*g +: ADDR_WIDTH]),
            .end_addr_i     (end_addr_i[ADDR_WIDTH*g +: ADDR_WIDTH]),
            .loop_count_i   (loop_count_i[LOOP_WIDTH*g +: LOOP_WIDTH]),
            .read_address_o (read_address_o[ADDR_WIDTH*g +: ADDR_WIDTH]),
            .sync_out_o     (sync_out_o[g]),
            .busy_o         (busy_o[g]),
            .done_o         (done_o[g]),
            .config_error_o (config_error_o[g])
        );
    end

endmodule

// File: tb/tb_waveform_playback_sequencer.sv
// Scoreboard bench: expected address/sync sequences are queued as stimulus is driven and matched at each negedge.
module tb_waveform_playback_sequencer;

    localparam int CH = 2;
    localparam int AW = 14;
    localparam int LW = 16;
    localparam int SD = 3;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [CH-1:0]    enable = '0;
    logic [CH-1:0]    trigger = '0;
    logic [CH-1:0]    restart = '0;
    logic [2*CH-1:0]  mode = '0;
    logic [AW*CH-1:0] start_addr = '0;
    logic [AW*CH-1:0] end_addr = '0;
    logic [LW*CH-1:0] loop_count = '0;
    logic [AW*CH-1:0] read_address;
    logic [CH-1:0]    sync_out;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    done;
    logic [CH-1:0]    config_error;

    waveform_playback_sequencer #(
        .CHANNELS   (CH),
        .ADDR_WIDTH (AW),
        .LOOP_WIDTH (LW),
        .SYNC_DELAY (SD)
    ) dut (
        .clock_i        (clock),
        .reset_ni       (reset_n),
        .enable_i       (enable),
        .trigger_i      (trigger),
        .restart_i      (restart),
        .mode_i         (mode),
        .start_addr_i   (start_addr),
        .end_addr_i     (end_addr),
        .loop_count_i   (loop_count),
        .read_address_o (read_address),
        .sync_out_o     (sync_out),
        .busy_o         (busy),
        .done_o         (done),
        .config_error_o (config_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        bit sync;
    } exp_t;

    exp_t exp_q[$];
    int   sync_due[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   mon_ch = 0;
    int   n_obs = 0;
    int   n_sync = 0;
    int   n_done = 0;
    int   n_extra = 0;
    int   last_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(negedge clock) begin : monitor
        logic [AW-1:0] a;
        exp_t e;
        cyc++;
        if (mon_en) begin
            a = read_address[mon_ch*AW +: AW];
            if (busy[mon_ch]) begin
                n_obs++;
                last_busy = cyc;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("addr", 32'(a), e.addr);
                    if (e.sync) sync_due.push_back(cyc + SD);
                end else begin
                    n_extra++;
                end
            end
            if (sync_out[mon_ch]) begin
                n_sync++;
                if (sync_due.size() > 0) chk("sync_time", cyc, sync_due.pop_front());
            end
            if (done[mon_ch]) begin
                n_done++;
                chk("done_time", cyc, last_busy + 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input int m, input int s, input int e, input int l);
        mode[2*ch +: 2]        = 2'(m);
        start_addr[AW*ch +: AW] = AW'(s);
        end_addr[AW*ch +: AW]   = AW'(e);
        loop_count[LW*ch +: LW] = LW'(l);
    endtask

    task automatic expect_pass(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{addr: (s + i) % (1 << AW), sync: (i == 0)});
        end
    endtask

    task automatic finish_case(input string tag, input int n_addr, input int n_s, input int n_d);
        tick(SD + 4);
        chk({tag, "_addrs"}, n_obs, n_addr);
        chk({tag, "_extra"}, n_extra, 0);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        chk({tag, "_syncs"}, n_sync, n_s);
        chk({tag, "_sync_left"}, sync_due.size(), 0);
        chk({tag, "_done"}, n_done, n_d);
        n_obs = 0;
        n_sync = 0;
        n_done = 0;
        n_extra = 0;
        exp_q.delete();
        sync_due.delete();
    endtask

    initial begin
        #12;
        chk("rst_addr", read_address, 0);
        chk("rst_sync", sync_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", config_error, 0);
        reset_n = 1'b1;
        tick(1);
        mon_ch = 0;
        mon_en = 1'b1;

        // continuous play, 4-word segment
        set_ch(0, 0, 16, 20, 0);
        for (int p = 0; p < 3; p++) expect_pass(16, 4);
        enable[0] = 1'b1;
        tick(12);
        enable[0] = 1'b0;
        finish_case("cont", 12, 3, 0);
        chk("cont_hold", read_address[AW-1:0], 19);

        // one-shot plus retrigger
        set_ch(0, 1, 0, 8, 0);
        enable[0] = 1'b1;
        tick(2);
        chk("os_armed_busy", busy[0], 0);
        expect_pass(0, 8);
        trigger[0] = 1'b1;
        tick(1);
        trigger[0] = 1'b0;
        tick(10);
        finish_case("oneshot", 8, 1, 1);
        chk("os_busy_after", busy[0], 0);
        chk("os_hold", read_address[AW-1:0], 7);
        expect_pass(0, 8);
        trigger[0] = 1'b1;
        tick(1);
        trigger[0] = 1'b0;
        tick(10);
        finish_case("retrig", 8, 1, 1);

        // N-repeat with an ignored mid-play trigger edge
        set_ch(0, 2, 40, 45, 2);
        for (int p = 0; p < 3; p++) expect_pass(40, 5);
        trigger[0] = 1'b1;
        tick(1);
        trigger[0] = 1'b0;
        tick(5);
        trigger[0] = 1'b1;
        tick(1);
        trigger[0] = 1'b0;
        tick(15);
        finish_case("nrep", 15, 3, 1);

        // segment wrapping through address 0
        enable[0] = 1'b0;
        tick(2);
        set_ch(0, 0, 16382, 2, 0);
        expect_pass(16382, 4);
        expect_pass(16382, 4);
        enable[0] = 1'b1;
        tick(8);
        enable[0] = 1'b0;
        finish_case("wrap", 8, 2, 0);

        // zero-length segment
        set_ch(0, 0, 100, 100, 0);
        enable[0] = 1'b1;
        tick(3);
        chk("zl_err", config_error[0], 1);
        chk("zl_busy", busy[0], 0);
        finish_case("zerolen", 0, 0, 0);
        chk("zl_hold", read_address[AW-1:0], 1);
        enable[0] = 1'b0;
        tick(1);
        chk("zl_clear", config_error[0], 0);

        // gated: trigger held for 10 cycles
        set_ch(0, 3, 200, 204, 0);
        enable[0] = 1'b1;
        tick(2);
        for (int p = 0; p < 3; p++) expect_pass(200, 4);
        trigger[0] = 1'b1;
        tick(10);
        trigger[0] = 1'b0;
        finish_case("gated", 12, 3, 1);

        // restart mid-pass
        exp_q.push_back('{addr: 200, sync: 1'b1});
        exp_q.push_back('{addr: 201, sync: 1'b0});
        expect_pass(200, 4);
        trigger[0] = 1'b1;
        tick(2);
        restart[0] = 1'b1;
        tick(1);
        restart[0] = 1'b0;
        trigger[0] = 1'b0;
        finish_case("restart", 6, 2, 1);

        // async reset with both channels active
        enable[0] = 1'b0;
        tick(2);
        mon_en = 1'b0;
        set_ch(0, 0, 16, 20, 0);
        set_ch(1, 1, 500, 600, 0);
        enable = 2'b11;
        tick(2);
        trigger[1] = 1'b1;
        tick(1);
        trigger[1] = 1'b0;
        tick(5);
        chk("pre_busy1", busy[1], 1);
        chk("pre_busy0", busy[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_addr", read_address, 0);
        chk("arst_sync", sync_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", config_error, 0);
        #3 reset_n = 1'b1;
        expect_pass(16, 4);
        expect_pass(16, 4);
        mon_ch = 0;
        mon_en = 1'b1;
        tick(8);
        enable[0] = 1'b0;
        finish_case("recover", 8, 2, 0);
        chk("rec_busy1", busy[1], 0);
        chk("rec_addr1", read_address[AW +: AW], 0);

        mon_ch = 1;
        expect_pass(500, 100);
        trigger[1] = 1'b1;
        tick(1);
        trigger[1] = 1'b0;
        tick(100);
        finish_case("rec_ch1", 100, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
